payload_monitor: RTL and testbench
==================================

# payload_monitor

Runtime checker for one registered pass-through stage in the datapath under test. It taps the stage's input and output, predicts the output by delaying the input, and flags every cycle where the two disagree. It records the first corruption (cycle stamp and additive delta), counts corruptions, and detects periodic firing, such as a counter-triggered payload. It sits beside the stage as a passive observer and never drives the datapath.

## Interface
- `WIDTH`, default 16: monitored data width.
- `LAT`, default 1: latency of the observed stage in cycles; legal range 1..4.
- `THRESH`, default 1: mismatch count at which `alarm` asserts; legal range 1..2^CNT_W-1.
- `CNT_W`, default 8: width of `mismatch_count`.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `en` input 1: monitoring enable; level-sensitive.
- `clear` input 1: synchronous clear of all status; single-cycle pulse.
- `mon_in` input WIDTH: input of the observed stage.
- `mon_out` input WIDTH: output of the observed stage.
- `mismatch_pulse` output 1: high for exactly one cycle per detected mismatch.
- `mismatch_count` output CNT_W: number of mismatches; saturating.
- `alarm` output 1: sticky; set when `mismatch_count` reaches THRESH.
- `first_stamp` output 16: cycle stamp of the first mismatch.
- `first_delta` output WIDTH: `mon_out` minus expected, mod 2^WIDTH, at the first mismatch.
- `last_period` output 16: stamp difference between the two most recent mismatches.
- `periodic` output 1: sticky; set when two consecutive periods are equal and nonzero.
- `state` output 2: encoding IDLE=0, FILL=1, WATCH=2, ALARM=3.

## Operation
**State machine**
- **IDLE**
  - Delay line and fill counter held at 0.
  - Goes to FILL when `en` is 1.
- **FILL**
  - Delay line captures `mon_in` each cycle.
  - Fill counter counts up to LAT, then the FSM goes to WATCH.
  - No compares are made in FILL.
- **WATCH**
  - Every cycle: expected = `mon_in` delayed LAT cycles. Compare `mon_out` against expected.
  - Goes to ALARM on the edge where `alarm` sets.
- **ALARM**
  - Same compare behaviour as WATCH.
  - `clear` returns the FSM to WATCH.
- From any state, `en`=0 returns the FSM to IDLE on the next edge. Status outputs are retained. The delay line is discarded, so a later FILL re-primes it.

**Cycle stamp**
- 16-bit counter, zeroed on entry to FILL.
- Increments every WATCH/ALARM cycle; the first compare cycle has stamp 0.
- Wraps 0xFFFF to 0x0000.
- Period = current stamp minus previous mismatch stamp, mod 2^16.

**On a mismatch in a compare cycle**
- `mismatch_count` increments, saturating at 2^CNT_W-1.
- If this is the first mismatch since reset/clear: latch `first_stamp` and `first_delta`.
- If it is not the first: latch `last_period`.
- `periodic` sets if the new period equals the prior `last_period` and is nonzero.

**clear**
- Zeroes `mismatch_count`, `alarm`, `periodic`, `first_*`, `last_period`, and the has-first flag.
- Does not touch the delay line, fill counter, or cycle stamp.
- Clear has priority: a mismatch in the same cycle as `clear` is discarded.
- If `en`=0 in the same cycle, the FSM goes to IDLE (`en` wins over the ALARM→WATCH exit).

## Timing
- Reset: all outputs 0, `state`=IDLE, delay line 0.
- Compare cycle t uses `mon_in` sampled at edge t-LAT and `mon_out` sampled at edge t.
- Latency from that compare cycle to outputs: 1 cycle.
  - `mismatch_pulse`, count, `first_*`, `last_period`, `periodic` all update on edge t+1.
  - `alarm` and the ALARM state also update on edge t+1.
- `en` rising at edge e: FILL occupies LAT cycles, and the first compare happens LAT cycles after e.
- `rst` asserted mid-operation: all state and outputs clear immediately, asynchronously.
- Back-to-back mismatches: a pulse every cycle with period 1. `periodic` sets on the third consecutive one.

## Test plan
- **Clean path:** LAT=1, bench stage is an exact 1-cycle register, 1000 random words → `mismatch_count`=0, `alarm`=0, `state`=WATCH.
- **Periodic payload:** bench stage adds 0x0002 whenever its private 8-bit counter reaches 0xFF, first firing at compare stamp 255. Expected response:
  - 1st mismatch: `first_stamp`=255, `first_delta`=0x0002, `alarm`=1.
  - 2nd mismatch: `last_period`=256.
  - 3rd mismatch: `periodic`=1, `mismatch_count`=3.
- **Threshold and saturation:** THRESH=3, CNT_W=4, corrupt 20 consecutive cycles → `alarm` rises one cycle after the 3rd mismatch; count sticks at 15.
- **Clear collision:** `clear` in the same cycle as a mismatch → count=0, no pulse, `state` WATCH. The next mismatch re-latches `first_*`.
- **Enable/latency:** LAT=3, toggle `en` low for 5 cycles mid-stream then high → no compares for 3 cycles after re-enable, and no false mismatch from stale delay data.
- **Async reset mid-ALARM:** assert `rst` between edges → all outputs 0 before the next edge, `state`=IDLE.

Source files
------------

// File: rtl/payload_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : payload_monitor_if
//  Purpose  : Bundles the tap, control and status signals of payload_monitor.
//             slave  - the monitor: samples taps/control, drives status.
//             master - the environment: drives taps/control, reads status.
//  Ports    : en, clear            control (level enable, one-cycle clear)
//             mon_in, mon_out      taps on the observed stage input/output
//             mismatch_pulse, mismatch_count, alarm, first_stamp,
//             first_delta, last_period, periodic, state   status
//  Revision : 1.0  initial release
// ============================================================================
interface payload_monitor_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             en;
  logic             clear;
  logic [WIDTH-1:0] mon_in;
  logic [WIDTH-1:0] mon_out;
  logic             mismatch_pulse;
  logic [CNT_W-1:0] mismatch_count;
  logic             alarm;
  logic [15:0]      first_stamp;
  logic [WIDTH-1:0] first_delta;
  logic [15:0]      last_period;
  logic             periodic;
  logic [1:0]       state;

  modport master (
    output en, clear, mon_in, mon_out,
    input  mismatch_pulse, mismatch_count, alarm, first_stamp,
           first_delta, last_period, periodic, state
  );

  modport slave (
    input  en, clear, mon_in, mon_out,
    output mismatch_pulse, mismatch_count, alarm, first_stamp,
           first_delta, last_period, periodic, state
  );
endinterface
`default_nettype wire

// File: rtl/payload_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : payload_monitor
//  Purpose  : Passive checker for a LAT-cycle registered pass-through stage.
//             Predicts the stage output by delaying its input, flags every
//             disagreeing cycle, records the first corruption (stamp and
//             additive delta), counts corruptions and detects periodicity.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - payload_monitor_if.slave (taps, control, status)
//  Params   : WIDTH (data width, must match the interface), LAT (1..4),
//             THRESH (alarm level, 1..2^CNT_W-1), CNT_W (counter width,
//             must match the interface)
//  Revision : 1.0  initial release
// ============================================================================
module payload_monitor #(
  parameter int WIDTH  = 16,
  parameter int LAT    = 1,
  parameter int THRESH = 1,
  parameter int CNT_W  = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  payload_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WATCH = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_THRESH    = CNT_W'(THRESH);
  localparam logic [2:0]       C_FILL_LAST = 3'(LAT - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_dly [LAT];
  logic [2:0]       r_fill;
  logic [15:0]      r_stamp;
  logic [15:0]      r_prev_stamp;
  logic             r_has_first;
  logic             r_pulse;
  logic [CNT_W-1:0] r_count;
  logic             r_alarm;
  logic [15:0]      r_first_stamp;
  logic [WIDTH-1:0] r_first_delta;
  logic [15:0]      r_last_period;
  logic             r_periodic;

  logic             w_cmp;
  logic [WIDTH-1:0] w_expected;
  logic             w_hit;
  logic [CNT_W-1:0] w_count_nxt;
  logic [15:0]      w_period;

  // Compares only run while enabled in WATCH/ALARM; a clear in the same
  // cycle wins, so a colliding mismatch is dropped entirely.
  assign w_cmp       = bus.en && ((r_state == ST_WATCH) || (r_state == ST_ALARM));
  assign w_expected  = r_dly[LAT-1];
  assign w_hit       = w_cmp && (bus.mon_out != w_expected) && !bus.clear;
  assign w_count_nxt = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + 1'b1;
  assign w_period    = r_stamp - r_prev_stamp;

  // Delay line: zero whenever the FSM is (or is about to be) idle so that a
  // re-enable always primes it from fresh input data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) r_dly[i] <= '0;
    end else if (r_state == ST_IDLE || !bus.en) begin
      for (int i = 0; i < LAT; i++) r_dly[i] <= '0;
    end else begin
      r_dly[0] <= bus.mon_in;
      for (int i = 1; i < LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_fill        <= '0;
      r_stamp       <= '0;
      r_prev_stamp  <= '0;
      r_has_first   <= 1'b0;
      r_pulse       <= 1'b0;
      r_count       <= '0;
      r_alarm       <= 1'b0;
      r_first_stamp <= '0;
      r_first_delta <= '0;
      r_last_period <= '0;
      r_periodic    <= 1'b0;
    end else begin
      r_pulse <= w_hit;

      // Status
      if (bus.clear) begin
        r_count       <= '0;
        r_alarm       <= 1'b0;
        r_periodic    <= 1'b0;
        r_first_stamp <= '0;
        r_first_delta <= '0;
        r_last_period <= '0;
        r_has_first   <= 1'b0;
      end else if (w_hit) begin
        r_count      <= w_count_nxt;
        r_prev_stamp <= r_stamp;
        if (w_count_nxt >= C_THRESH) r_alarm <= 1'b1;
        if (!r_has_first) begin
          r_has_first   <= 1'b1;
          r_first_stamp <= r_stamp;
          r_first_delta <= bus.mon_out - w_expected;
        end else begin
          r_last_period <= w_period;
          if (w_period == r_last_period && w_period != 16'd0) r_periodic <= 1'b1;
        end
      end

      if (w_cmp) r_stamp <= r_stamp + 16'd1;

      // FSM
      if (!bus.en) begin
        r_state <= ST_IDLE;
        r_fill  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_FILL;
            r_fill  <= '0;
            r_stamp <= '0;
          end
          ST_FILL: begin
            r_fill <= r_fill + 3'd1;
            if (r_fill == C_FILL_LAST) r_state <= ST_WATCH;
          end
          ST_WATCH: begin
            if (w_hit && w_count_nxt >= C_THRESH) r_state <= ST_ALARM;
          end
          ST_ALARM: begin
            if (bus.clear) r_state <= ST_WATCH;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.mismatch_pulse = r_pulse;
  assign bus.mismatch_count = r_count;
  assign bus.alarm          = r_alarm;
  assign bus.first_stamp    = r_first_stamp;
  assign bus.first_delta    = r_first_delta;
  assign bus.last_period    = r_last_period;
  assign bus.periodic       = r_periodic;
  assign bus.state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_payload_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_payload_monitor
//  Purpose  : Directed bench for payload_monitor. Two monitors run side by
//             side: u0 (LAT=1, THRESH=1, CNT_W=8) and u1 (LAT=3, THRESH=3,
//             CNT_W=4), each watching a bench-built register stage whose
//             output can be corrupted by an additive term.
//  Revision : 1.0  initial release
// ============================================================================
module tb_payload_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  payload_monitor_if #(.WIDTH(16), .CNT_W(8)) if0 ();
  payload_monitor_if #(.WIDTH(16), .CNT_W(4)) if1 ();

  payload_monitor #(.WIDTH(16), .LAT(1), .THRESH(1), .CNT_W(8)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  payload_monitor #(.WIDTH(16), .LAT(3), .THRESH(3), .CNT_W(4)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  // Observed stages: exact registers plus a bench-controlled corruption.
  logic [15:0] corr0 = '0;
  logic [15:0] corr1 = '0;
  logic [15:0] s0_q;
  logic [15:0] s1_q [3];

  always_ff @(posedge clk) begin
    s0_q    <= if0.mon_in;
    s1_q[0] <= if1.mon_in;
    s1_q[1] <= s1_q[0];
    s1_q[2] <= s1_q[1];
  end
  assign if0.mon_out = s0_q + corr0;
  assign if1.mon_out = s1_q[2] + corr1;

  int nchk  = 0;
  int nfail = 0;
  int k0    = 0;   // consecutive enabled cycles seen by u0
  int k1    = 0;   // consecutive enabled cycles seen by u1
  bit q0 [$];
  bit q1 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: push the expected pulse for the current stimulus,
  // advance, then pop and compare once the result is visible.
  task automatic cyc();
    bit a0, a1, e0, e1;
    a0 = if0.en && (k0 >= 2);   // IDLE cycle + 1 FILL cycle precede compares
    a1 = if1.en && (k1 >= 4);   // IDLE cycle + 3 FILL cycles
    q0.push_back(a0 && !if0.clear && (corr0 != 16'h0));
    q1.push_back(a1 && !if1.clear && (corr1 != 16'h0));
    @(posedge clk);
    #1;
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    chk("pulse0", 32'(if0.mismatch_pulse), 32'(e0));
    chk("pulse1", 32'(if1.mismatch_pulse), 32'(e1));
    k0 = if0.en ? k0 + 1 : 0;
    k1 = if1.en ? k1 + 1 : 0;
    if0.mon_in = 16'($urandom);
    if1.mon_in = 16'($urandom);
  endtask

  // Run u0 with a corruption of 2 whenever its compare stamp low byte is
  // 0xFF, stopping after the cycle whose stamp is 'stop'.
  task automatic run0_to(input int stop);
    int st;
    do begin
      st    = k0 - 2;
      corr0 = (k0 >= 2 && (st % 256) == 255) ? 16'h0002 : 16'h0000;
      cyc();
    end while (st != stop);
    corr0 = '0;
  endtask

  initial begin
    int s;
    if0.en = 1'b0; if0.clear = 1'b0; if0.mon_in = '0;
    if1.en = 1'b0; if1.clear = 1'b0; if1.mon_in = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_pulse0", 32'(if0.mismatch_pulse), 32'd0);
    chk("rst_count0", 32'(if0.mismatch_count), 32'd0);
    chk("rst_alarm0", 32'(if0.alarm), 32'd0);
    chk("rst_fstamp0", 32'(if0.first_stamp), 32'd0);
    chk("rst_state0", 32'(if0.state), 32'd0);
    chk("rst_state1", 32'(if1.state), 32'd0);
    rst = 1'b0;

    // Clean path: 1000 random words through u0
    if0.en = 1'b1;
    repeat (1002) cyc();
    chk("clean_count", 32'(if0.mismatch_count), 32'd0);
    chk("clean_alarm", 32'(if0.alarm), 32'd0);
    chk("clean_state", 32'(if0.state), 32'd2);

    // Re-enable so the stamp restarts, then periodic payload
    if0.en = 1'b0;
    cyc();
    chk("idle_state", 32'(if0.state), 32'd0);
    if0.en = 1'b1;
    run0_to(255);
    chk("per_fstamp", 32'(if0.first_stamp), 32'd255);
    chk("per_fdelta", 32'(if0.first_delta), 32'h0002);
    chk("per_alarm", 32'(if0.alarm), 32'd1);
    chk("per_state", 32'(if0.state), 32'd3);
    chk("per_count1", 32'(if0.mismatch_count), 32'd1);
    run0_to(511);
    chk("per_period", 32'(if0.last_period), 32'd256);
    chk("per_notyet", 32'(if0.periodic), 32'd0);
    run0_to(767);
    chk("per_periodic", 32'(if0.periodic), 32'd1);
    chk("per_count3", 32'(if0.mismatch_count), 32'd3);

    // Clear collides with a mismatch
    corr0 = 16'h0005; if0.clear = 1'b1;
    cyc();
    corr0 = '0; if0.clear = 1'b0;
    chk("clr_count", 32'(if0.mismatch_count), 32'd0);
    chk("clr_state", 32'(if0.state), 32'd2);
    chk("clr_alarm", 32'(if0.alarm), 32'd0);
    chk("clr_periodic", 32'(if0.periodic), 32'd0);
    repeat (3) cyc();
    s = k0 - 2;
    corr0 = 16'h0010;
    cyc();
    corr0 = '0;
    chk("clr_fstamp", 32'(if0.first_stamp), 32'(s[15:0]));
    chk("clr_fdelta", 32'(if0.first_delta), 32'h0010);
    chk("clr_count1", 32'(if0.mismatch_count), 32'd1);

    // Threshold and saturation on u1
    if1.en = 1'b1;
    repeat (10) cyc();
    chk("thr_state_w", 32'(if1.state), 32'd2);
    for (int i = 1; i <= 20; i++) begin
      corr1 = 16'h0001;
      cyc();
      if (i == 2) chk("thr_alarm_lo", 32'(if1.alarm), 32'd0);
      if (i == 3) begin
        chk("thr_alarm_hi", 32'(if1.alarm), 32'd1);
        chk("thr_state_a", 32'(if1.state), 32'd3);
      end
    end
    corr1 = '0;
    chk("sat_count", 32'(if1.mismatch_count), 32'd15);
    chk("b2b_period", 32'(if1.last_period), 32'd1);
    chk("b2b_periodic", 32'(if1.periodic), 32'd1);

    // Enable / latency on u1
    if1.clear = 1'b1;
    cyc();
    if1.clear = 1'b0;
    chk("en_clr_state", 32'(if1.state), 32'd2);
    chk("en_clr_count", 32'(if1.mismatch_count), 32'd0);
    if1.en = 1'b0;
    corr1 = 16'h0001;
    repeat (5) cyc();
    chk("en_idle", 32'(if1.state), 32'd0);
    if1.en = 1'b1;
    corr1 = 16'h0007;
    repeat (4) cyc();
    corr1 = '0;
    repeat (20) cyc();
    chk("en_count", 32'(if1.mismatch_count), 32'd0);
    chk("en_state", 32'(if1.state), 32'd2);

    // Asynchronous reset while u0 is in ALARM
    corr0 = 16'h0003;
    cyc();
    corr0 = '0;
    chk("ar_state_pre", 32'(if0.state), 32'd3);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_pulse", 32'(if0.mismatch_pulse), 32'd0);
    chk("ar_count", 32'(if0.mismatch_count), 32'd0);
    chk("ar_alarm", 32'(if0.alarm), 32'd0);
    chk("ar_fstamp", 32'(if0.first_stamp), 32'd0);
    chk("ar_fdelta", 32'(if0.first_delta), 32'd0);
    chk("ar_period", 32'(if0.last_period), 32'd0);
    chk("ar_periodic", 32'(if0.periodic), 32'd0);
    chk("ar_state", 32'(if0.state), 32'd0);
    chk("ar_state1", 32'(if1.state), 32'd0);
    repeat (2) @(posedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
`default_nettype wire
